// File: rtl/rl_pkg.sv
// Shared types and constants for the Q-learning datapath (table updater and action selector).
package rl_pkg;

  localparam int Q_W   = 16;
  localparam int ROW_W = 64;
  localparam int N_ACT = 4;

  localparam logic [3:0] ACT_1 = 4'd1;
  localparam logic [3:0] ACT_2 = 4'd2;
  localparam logic [3:0] ACT_3 = 4'd3;
  localparam logic [3:0] ACT_4 = 4'd4;

  // Q8.8 constants
  localparam logic [Q_W-1:0] Q_ZERO = 16'h0000;
  localparam logic [Q_W-1:0] Q_ONE  = 16'h0100;
  localparam logic [Q_W-1:0] Q_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_CALC,
    ST_WRITE
  } upd_state_e;

  // Action 1..4 maps to row column 3..0 (act1 lives in the top 16 bits).
  function automatic logic [1:0] act2col(input logic [3:0] act);
    logic [3:0] c;
    c = ACT_4 - act;
    return c[1:0];
  endfunction

  function automatic logic act_legal(input logic [3:0] act);
    return (act >= ACT_1) && (act <= ACT_4);
  endfunction

endpackage

// File: rtl/q_max4.sv
// Combinational maximum of four unsigned Q8.8 values.
module q_max4
  import rl_pkg::*;
(
  input  logic [Q_W-1:0] in0,
  input  logic [Q_W-1:0] in1,
  input  logic [Q_W-1:0] in2,
  input  logic [Q_W-1:0] in3,
  output logic [Q_W-1:0] max_o
);

  logic [Q_W-1:0] m01;
  logic [Q_W-1:0] m23;

  // Two-level compare tree
  always_comb begin
    m01   = (in0 > in1) ? in0 : in1;
    m23   = (in2 > in3) ? in2 : in3;
    max_o = (m01 > m23) ? m01 : m23;
  end

endmodule

// File: rtl/q_table_updater.sv
// Q-table storage with a registered row read port and a 4-cycle TD-update engine.
module q_table_updater
  import rl_pkg::*;
#(
  parameter int         N_STATES = 25,
  parameter int         S_W      = 5,
  parameter logic [7:0] ALPHA    = 8'd26,
  parameter logic [7:0] GAMMA    = 8'd230,
  parameter logic [15:0] INIT_Q  = 16'h0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [S_W-1:0] rd_state,
  output logic [63:0]    q_values,
  input  logic           upd_valid,
  output logic           upd_ready,
  input  logic [S_W-1:0] upd_state,
  input  logic [3:0]     upd_action,
  input  logic [15:0]    upd_reward,
  input  logic [S_W-1:0] upd_next_state,
  output logic           upd_done,
  output logic           upd_err
);

  localparam logic [S_W-1:0] LAST_STATE = S_W'(N_STATES - 1);

  upd_state_e state_q, state_d;

  logic [ROW_W-1:0] table_q [N_STATES];
  logic [ROW_W-1:0] table_d [N_STATES];
  logic [ROW_W-1:0] q_values_q, q_values_d;

  logic [S_W-1:0] s_q, s_d, sp_q, sp_d;
  logic [1:0]     col_q, col_d;
  logic [15:0]    r_q, r_d;
  logic           rej_q, rej_d;
  logic [Q_W-1:0] q_sa_q, q_sa_d, maxq_q, maxq_d, q_new_q, q_new_d;
  logic           done_q, done_d, err_q, err_d;

  logic accept, latch_rd, latch_calc, commit;

  logic [ROW_W-1:0] row_s, row_sp;
  logic [Q_W-1:0]   row_sp_max;

  logic [23:0]        g_prod;
  logic [15:0]        g;
  logic signed [17:0] tgt, d;
  logic signed [26:0] a_prod;
  logic signed [18:0] step;
  logic signed [19:0] sum;
  logic [Q_W-1:0]     q_clamped;

  // State register and all datapath flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      for (int unsigned i = 0; i < N_STATES; i++) table_q[i] <= {4{INIT_Q}};
      q_values_q <= '0;
      s_q        <= '0;
      sp_q       <= '0;
      col_q      <= '0;
      r_q        <= '0;
      rej_q      <= 1'b0;
      q_sa_q     <= '0;
      maxq_q     <= '0;
      q_new_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      table_q    <= table_d;
      q_values_q <= q_values_d;
      s_q        <= s_d;
      sp_q       <= sp_d;
      col_q      <= col_d;
      r_q        <= r_d;
      rej_q      <= rej_d;
      q_sa_q     <= q_sa_d;
      maxq_q     <= maxq_d;
      q_new_q    <= q_new_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: fixed four-cycle walk, rejected requests included
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (upd_valid) state_d = ST_READ;
      ST_READ:  state_d = ST_CALC;
      ST_CALC:  state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    upd_ready  = (state_q == ST_IDLE);
    accept     = upd_valid && (state_q == ST_IDLE);
    latch_rd   = (state_q == ST_READ);
    latch_calc = (state_q == ST_CALC);
    commit     = (state_q == ST_WRITE) && !rej_q;
    done_d     = (state_q == ST_WRITE);
    err_d      = (state_q == ST_WRITE) && rej_q;
  end

  // Request capture at the handshake edge
  always_comb begin
    s_d   = s_q;
    sp_d  = sp_q;
    col_d = col_q;
    r_d   = r_q;
    rej_d = rej_q;
    if (accept) begin
      s_d   = upd_state;
      sp_d  = upd_next_state;
      col_d = act2col(upd_action);
      r_d   = upd_reward;
      rej_d = !act_legal(upd_action) || (upd_state > LAST_STATE) ||
              (upd_next_state > LAST_STATE);
    end
  end

  // Row fetch for s and s'; out-of-range indices read as zero so rejects stay X-free
  always_comb begin
    row_s  = (s_q  <= LAST_STATE) ? table_q[s_q]  : '0;
    row_sp = (sp_q <= LAST_STATE) ? table_q[sp_q] : '0;
  end

  q_max4 u_max4 (
    .in0   (row_sp[15:0]),
    .in1   (row_sp[31:16]),
    .in2   (row_sp[47:32]),
    .in3   (row_sp[63:48]),
    .max_o (row_sp_max)
  );

  // READ-stage latches
  always_comb begin
    q_sa_d = q_sa_q;
    maxq_d = maxq_q;
    if (latch_rd) begin
      q_sa_d = row_s[{col_q, 4'b0000} +: Q_W];
      maxq_d = row_sp_max;
    end
  end

  // TD arithmetic on the READ-stage latches, clamped into unsigned Q8.8
  always_comb begin
    g_prod = {16'b0, GAMMA} * {8'b0, maxq_q};
    g      = 16'(g_prod >> 8);
    tgt    = $signed({{2{r_q[15]}}, r_q}) + $signed({2'b00, g});
    d      = tgt - $signed({2'b00, q_sa_q});
    a_prod = $signed({1'b0, ALPHA}) * d;
    step   = 19'(a_prod >>> 8);
    sum    = $signed({4'b0000, q_sa_q}) + $signed({step[18], step});
    if (sum[19])            q_clamped = Q_ZERO;
    else if (|sum[18:16])   q_clamped = Q_MAX;
    else                    q_clamped = sum[15:0];
    q_new_d = latch_calc ? q_clamped : q_new_q;
  end

  // Table write in WRITE for accepted requests
  always_comb begin
    table_d = table_q;
    if (commit) table_d[s_q][{col_q, 4'b0000} +: Q_W] = q_new_q;
  end

  // Registered read port sees pre-edge table contents
  always_comb begin
    q_values_d = (rd_state <= LAST_STATE) ? table_q[rd_state] : '0;
  end

  assign q_values = q_values_q;
  assign upd_done = done_q;
  assign upd_err  = err_q;

endmodule

// File: tb/tb_q_table_updater.sv
// Directed scoreboard bench for q_table_updater (default build plus an ALPHA=8'hFF build).
module tb_q_table_updater;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rd_state = '0;
  logic        valid0 = 1'b0, valid1 = 1'b0;
  logic [4:0]  upd_state = '0, upd_next_state = '0;
  logic [3:0]  upd_action = '0;
  logic [15:0] upd_reward = '0;

  logic [63:0] qv0, qv1;
  logic        rdy0, rdy1, done0, done1, err0, err1;

  int vectors = 0;
  int fails   = 0;
  int dcnt0   = 0;
  int dcnt1   = 0;

  logic [15:0] m [2][25][4];
  bit sb0 [$];
  bit sb1 [$];

  always #5 clk = ~clk;

  q_table_updater #(.N_STATES(25), .S_W(5), .ALPHA(8'd26), .GAMMA(8'd230), .INIT_Q(16'h0)) dut0 (
    .clk(clk), .rst_n(rst_n), .rd_state(rd_state), .q_values(qv0),
    .upd_valid(valid0), .upd_ready(rdy0), .upd_state(upd_state), .upd_action(upd_action),
    .upd_reward(upd_reward), .upd_next_state(upd_next_state), .upd_done(done0), .upd_err(err0)
  );

  q_table_updater #(.N_STATES(25), .S_W(5), .ALPHA(8'hFF), .GAMMA(8'd230), .INIT_Q(16'h0)) dut1 (
    .clk(clk), .rst_n(rst_n), .rd_state(rd_state), .q_values(qv1),
    .upd_valid(valid1), .upd_ready(rdy1), .upd_state(upd_state), .upd_action(upd_action),
    .upd_reward(upd_reward), .upd_next_state(upd_next_state), .upd_done(done1), .upd_err(err1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] td(input int alpha, input int qsa, input int maxq,
                                     input logic [15:0] r);
    int g, tgt, dd, st, nq;
    g   = (230 * maxq) >> 8;
    tgt = int'($signed(r)) + g;
    dd  = tgt - qsa;
    st  = (alpha * dd) >>> 8;
    nq  = qsa + st;
    if (nq < 0) nq = 0;
    if (nq > 65535) nq = 65535;
    return 16'(nq);
  endfunction

  function automatic logic [63:0] mrow(input int sel, input int r);
    return {m[sel][r][3], m[sel][r][2], m[sel][r][1], m[sel][r][0]};
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 25; r++)
        for (int c = 0; c < 4; c++) m[k][r][c] = 16'h0;
  endtask

  // Model update plus scoreboard push; returns nothing, updates m in request order
  task automatic expect_req(input int sel, input logic [4:0] s, input logic [3:0] a,
                            input logic [15:0] r, input logic [4:0] sp);
    bit rej;
    int col, qsa, mx;
    rej = (a == 4'd0) || (a > 4'd4) || (s >= 5'd25) || (sp >= 5'd25);
    if (!rej) begin
      col = 4 - int'(a);
      qsa = int'(m[sel][s][col]);
      mx  = 0;
      for (int c = 0; c < 4; c++) if (int'(m[sel][sp][c]) > mx) mx = int'(m[sel][sp][c]);
      m[sel][s][col] = td(sel == 1 ? 255 : 26, qsa, mx, r);
    end
    if (sel == 0) sb0.push_back(rej); else sb1.push_back(rej);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Issue one request, scramble inputs after capture, wait (bounded) for upd_done
  task automatic do_update(input int sel, input logic [4:0] s, input logic [3:0] a,
                           input logic [15:0] r, input logic [4:0] sp);
    int n, base;
    expect_req(sel, s, a, r, sp);
    upd_state = s; upd_action = a; upd_reward = r; upd_next_state = sp;
    if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
    base = (sel == 0) ? dcnt0 : dcnt1;
    @(posedge clk);
    #1;
    valid0 = 1'b0; valid1 = 1'b0;
    upd_state = 5'($urandom); upd_action = 4'($urandom);
    upd_reward = 16'($urandom); upd_next_state = 5'($urandom);
    n = 0;
    while (((sel == 0) ? dcnt0 : dcnt1) == base && n < 12) begin
      tick();
      n++;
    end
    chk("done_latency", 64'(n), 64'd4);
  endtask

  task automatic check_entry(input int sel, input logic [4:0] s, input int col, input string tag);
    logic [63:0] v;
    rd_state = s;
    tick();
    v = (sel == 0) ? qv0 : qv1;
    chk(tag, 64'(v[16*col +: 16]), 64'(m[sel][s][col]));
  endtask

  task automatic sweep(input int sel, input string tag);
    for (int r = 0; r < 25; r++) begin
      rd_state = 5'(r);
      tick();
      chk(tag, (sel == 0) ? qv0 : qv1, mrow(sel, r));
    end
  endtask

  // Scoreboard pop when a DUT reports completion
  always @(negedge clk) begin
    if (done0) begin
      if (sb0.size() == 0) chk("done0_no_req", 64'(done0), 64'd0);
      else chk("err0", 64'(err0), 64'(sb0.pop_front()));
      dcnt0++;
    end else if (err0) chk("err0_without_done", 64'(err0), 64'd0);
    if (done1) begin
      if (sb1.size() == 0) chk("done1_no_req", 64'(done1), 64'd0);
      else chk("err1", 64'(err1), 64'(sb1.pop_front()));
      dcnt1++;
    end else if (err1) chk("err1_without_done", 64'(err1), 64'd0);
  end

  initial begin
    int base;
    logic [63:0] v;
    mreset();

    // 1: reset state and full-table sweep
    repeat (3) tick();
    chk("rst_ready", 64'(rdy0), 64'd1);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_err", 64'(err0), 64'd0);
    chk("rst_qv", qv0, 64'h0);
    rst_n = 1'b1;
    tick();
    sweep(0, "reset_row");
    sweep(1, "reset_row_a255");
    chk("idle_ready", 64'(rdy0), 64'd1);

    // 2: basic update
    do_update(0, 5'd3, 4'd4, 16'h0100, 5'd4);
    check_entry(0, 5'd3, 0, "basic_row3_act4");
    v = qv0;
    chk("basic_const", 64'(v[15:0]), 64'h001A);

    // 3: bootstrap from the updated row
    do_update(0, 5'd2, 4'd1, 16'h0000, 5'd3);
    check_entry(0, 5'd2, 3, "boot_row2_act1");
    v = qv0;
    chk("boot_const", 64'(v[63:48]), 64'h0002);
    sweep(0, "boot_table");

    // 4: clamp low, then saturate high on the ALPHA=8'hFF build
    do_update(0, 5'd0, 4'd2, 16'h8000, 5'd0);
    check_entry(0, 5'd0, 2, "clamp_low");
    for (int i = 0; i < 5; i++) begin
      do_update(1, 5'd0, 4'd2, 16'h7FFF, 5'd0);
      check_entry(1, 5'd0, 2, "sat_step");
    end
    v = qv1;
    chk("sat_const", 64'(v[47:32]), 64'hFFFF);
    do_update(1, 5'd0, 4'd2, 16'h7FFF, 5'd0);
    check_entry(1, 5'd0, 2, "sat_hold");

    // 5: rejects leave the table untouched
    do_update(0, 5'd1, 4'd0, 16'h0100, 5'd2);
    do_update(0, 5'd1, 4'd2, 16'h0100, 5'd25);
    do_update(0, 5'd25, 4'd1, 16'h0100, 5'd2);
    do_update(0, 5'd1, 4'd5, 16'h0100, 5'd2);
    sweep(0, "reject_table");
    rd_state = 5'd25;
    tick();
    chk("rd_oob25", qv0, 64'h0);
    rd_state = 5'd31;
    tick();
    chk("rd_oob31", qv0, 64'h0);

    // 6a: held upd_valid accepts only at E0 and E4
    base = dcnt0;
    expect_req(0, 5'd1, 4'd3, 16'h0100, 5'd4);
    expect_req(0, 5'd1, 4'd3, 16'h0100, 5'd4);
    upd_state = 5'd1; upd_action = 4'd3; upd_reward = 16'h0100; upd_next_state = 5'd4;
    valid0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("b2b_ready", 64'(rdy0), (k == 0 || k == 4) ? 64'd1 : 64'd0);
      tick();
    end
    valid0 = 1'b0;
    tick();
    chk("b2b_done_count", 64'(dcnt0 - base), 64'd2);
    check_entry(0, 5'd1, 1, "b2b_row1_act3");

    // 6b: reset during CALC discards the update
    base = dcnt0;
    upd_state = 5'd4; upd_action = 4'd1; upd_reward = 16'h0100; upd_next_state = 5'd4;
    valid0 = 1'b1;
    @(posedge clk);
    #1;
    valid0 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_calc_ready", 64'(rdy0), 64'd1);
    chk("rst_calc_qv", qv0, 64'h0);
    mreset();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(rdy0), 64'd1);
    repeat (6) tick();
    chk("post_rst_no_done", 64'(dcnt0 - base), 64'd0);
    sweep(0, "post_rst_table");
    sweep(1, "post_rst_table_a255");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
